// File: rtl/baud_tick_gen.sv
// Baud-rate tick generator: programmable clk divider feeding an oversample counter (bit / mid-bit ticks).
// Optional fractional-divide accumulator enabled by defining BAUD_TICK_FRAC_EN.
module baud_tick_gen #(
  parameter int CNT_W      = 16,
  parameter int INITIAL_M  = 166,
  parameter int OVERSAMPLE = 16,
  parameter int OS_W       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             sync_clr,
  input  logic             set_m,
  input  logic [CNT_W-1:0] m,
`ifdef BAUD_TICK_FRAC_EN
  input  logic [3:0]       m_frac,
`endif
  output logic             tick,
  output logic             bit_tick,
  output logic             mid_tick,
  output logic [CNT_W-1:0] m_active,
  output logic             m_pending
);

  localparam logic [CNT_W-1:0] M_INIT  = CNT_W'(INITIAL_M);
  localparam logic [OS_W-1:0]  OS_LAST = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0]  OS_MID  = OS_W'(OVERSAMPLE / 2 - 1);

  logic [CNT_W-1:0] counter_r, counter_s;
  logic [OS_W-1:0]  os_cnt_r, os_cnt_s;
  logic [CNT_W-1:0] m_active_r, m_active_s;
  logic [CNT_W-1:0] pend_r, pend_s;
  logic             m_pending_r, m_pending_s;
  logic             tick_r, tick_s;
  logic             bit_tick_r, bit_tick_s;
  logic             mid_tick_r, mid_tick_s;
  logic             at_top_s;
  logic             stretch_hold_s;

`ifdef BAUD_TICK_FRAC_EN
  logic [3:0] acc_r, acc_s;
  logic [3:0] frac_active_r, frac_active_s;
  logic [3:0] frac_pend_r, frac_pend_s;
  logic       stretch_r, stretch_s;
  logic [4:0] frac_sum_s;

  // A carry out of the accumulator holds the counter at the top for one extra cycle.
  assign stretch_hold_s = stretch_r;
`else
  // Integer-only divider never stretches a period.
  assign stretch_hold_s = 1'b0;
`endif

  // Divider terminal-count detect, full CNT_W compare.
  assign at_top_s = (counter_r == m_active_r);

  // Next-state logic: reset handled in the register, here sync_clr > counting, set_m in parallel.
  always_comb begin
    counter_s   = counter_r;
    os_cnt_s    = os_cnt_r;
    m_active_s  = m_active_r;
    pend_s      = pend_r;
    m_pending_s = m_pending_r;
    tick_s      = 1'b0;
    bit_tick_s  = 1'b0;
    mid_tick_s  = 1'b0;
`ifdef BAUD_TICK_FRAC_EN
    acc_s         = acc_r;
    frac_active_s = frac_active_r;
    frac_pend_s   = frac_pend_r;
    stretch_s     = stretch_r;
    frac_sum_s    = 5'd0;
`endif

    if (sync_clr) begin
      counter_s = '0;
      os_cnt_s  = '0;
      if (m_pending_r) begin
        m_active_s  = pend_r;
        m_pending_s = 1'b0;
`ifdef BAUD_TICK_FRAC_EN
        frac_active_s = frac_pend_r;
`endif
      end else begin
        m_active_s = m_active_r;
      end
`ifdef BAUD_TICK_FRAC_EN
      acc_s     = 4'd0;
      stretch_s = 1'b0;
`endif
    end else if (enable) begin
      if (at_top_s && stretch_hold_s) begin
        counter_s = counter_r;
`ifdef BAUD_TICK_FRAC_EN
        stretch_s = 1'b0;
`endif
      end else if (at_top_s) begin
        counter_s = '0;
        tick_s    = 1'b1;
        if (os_cnt_r == OS_LAST) begin
          os_cnt_s   = '0;
          bit_tick_s = 1'b1;
        end else begin
          os_cnt_s = os_cnt_r + OS_W'(1);
        end
        if (os_cnt_r == OS_MID) begin
          mid_tick_s = 1'b1;
        end else begin
          mid_tick_s = 1'b0;
        end
`ifdef BAUD_TICK_FRAC_EN
        frac_sum_s = {1'b0, acc_r} + {1'b0, frac_active_r};
        acc_s      = frac_sum_s[3:0];
        stretch_s  = frac_sum_s[4];
`endif
        // Pending modulus only takes effect at a wrap, so no runt or stretched period.
        if (m_pending_r) begin
          m_active_s  = pend_r;
          m_pending_s = 1'b0;
`ifdef BAUD_TICK_FRAC_EN
          frac_active_s = frac_pend_r;
`endif
        end else begin
          m_active_s = m_active_r;
        end
      end else begin
        counter_s = counter_r + CNT_W'(1);
      end
    end else begin
      counter_s = counter_r;
    end

    // A capture in the same cycle as an apply re-arms the pending flag for the next wrap.
    if (set_m) begin
      pend_s      = m;
      m_pending_s = 1'b1;
`ifdef BAUD_TICK_FRAC_EN
      frac_pend_s = m_frac;
`endif
    end else begin
      pend_s = pend_s;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      counter_r   <= '0;
      os_cnt_r    <= '0;
      m_active_r  <= M_INIT;
      pend_r      <= M_INIT;
      m_pending_r <= 1'b0;
      tick_r      <= 1'b0;
      bit_tick_r  <= 1'b0;
      mid_tick_r  <= 1'b0;
`ifdef BAUD_TICK_FRAC_EN
      acc_r         <= 4'd0;
      frac_active_r <= 4'd0;
      frac_pend_r   <= 4'd0;
      stretch_r     <= 1'b0;
`endif
    end else begin
      counter_r   <= counter_s;
      os_cnt_r    <= os_cnt_s;
      m_active_r  <= m_active_s;
      pend_r      <= pend_s;
      m_pending_r <= m_pending_s;
      tick_r      <= tick_s;
      bit_tick_r  <= bit_tick_s;
      mid_tick_r  <= mid_tick_s;
`ifdef BAUD_TICK_FRAC_EN
      acc_r         <= acc_s;
      frac_active_r <= frac_active_s;
      frac_pend_r   <= frac_pend_s;
      stretch_r     <= stretch_s;
`endif
    end
  end

  assign tick      = tick_r;
  assign bit_tick  = bit_tick_r;
  assign mid_tick  = mid_tick_r;
  assign m_active  = m_active_r;
  assign m_pending = m_pending_r;

endmodule

// File: tb/tb_baud_tick_gen.sv
// Directed self-checking bench for baud_tick_gen (INITIAL_M=3, OVERSAMPLE=4, default build).
module tb_baud_tick_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       sync_clr;
  logic       set_m;
  logic [7:0] m;
  logic       tick;
  logic       bit_tick;
  logic       mid_tick;
  logic [7:0] m_active;
  logic       m_pending;

  int vectors = 0;
  int miscompares = 0;

  baud_tick_gen #(
    .CNT_W(8), .INITIAL_M(3), .OVERSAMPLE(4), .OS_W(2)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .sync_clr(sync_clr),
    .set_m(set_m), .m(m), .tick(tick), .bit_tick(bit_tick),
    .mid_tick(mid_tick), .m_active(m_active), .m_pending(m_pending)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the DUT at "cycle 0": counter 0, os_cnt 0, m_active 3.
  task automatic do_reset();
    reset = 1'b1; enable = 1'b1; sync_clr = 1'b0; set_m = 1'b0; m = 8'd0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [2:0] exp;
    do_reset();
    vectors++;
    if ({tick, mid_tick, bit_tick, m_pending} !== 4'b0000 || m_active !== 8'd3) begin
      miscompares++;
      $display("FAIL reset_state: got t/m/b/p=%b m_active=%0d want 0000 and 3",
               {tick, mid_tick, bit_tick, m_pending}, m_active);
    end
    for (int c = 1; c <= 16; c++) begin
      step();
      exp = {(c % 4 == 0), (c == 8), (c == 16)};
      vectors++;
      if ({tick, mid_tick, bit_tick} !== exp) begin
        miscompares++;
        $display("FAIL reset_seq cycle %0d: got tick/mid/bit=%b want %b", c, {tick, mid_tick, bit_tick}, exp);
      end
    end
  endtask

  task automatic test_set_m();
    logic [2:0] exp;
    do_reset();
    step();                       // counter = 1
    set_m = 1'b1; m = 8'd7;
    step();                       // cycle 2
    set_m = 1'b0;
    vectors++;
    if (m_pending !== 1'b1 || m_active !== 8'd3 || tick !== 1'b0) begin
      miscompares++;
      $display("FAIL set_m_pending: got p=%b m_active=%0d tick=%b want 1 3 0", m_pending, m_active, tick);
    end
    step();                       // cycle 3
    vectors++;
    if (tick !== 1'b0 || m_pending !== 1'b1) begin
      miscompares++;
      $display("FAIL set_m_old_period: got tick=%b p=%b want 0 1", tick, m_pending);
    end
    step();                       // cycle 4: wrap with old modulus
    vectors++;
    if (tick !== 1'b1 || m_active !== 8'd7 || m_pending !== 1'b0) begin
      miscompares++;
      $display("FAIL set_m_apply: got tick=%b m_active=%0d p=%b want 1 7 0", tick, m_active, m_pending);
    end
    for (int k = 1; k <= 16; k++) begin
      step();
      exp = {(k % 8 == 0), (k == 8), 1'b0};
      vectors++;
      if ({tick, mid_tick, bit_tick} !== exp) begin
        miscompares++;
        $display("FAIL set_m_new_period k=%0d: got tick/mid/bit=%b want %b", k, {tick, mid_tick, bit_tick}, exp);
      end
    end
  endtask

  task automatic test_freeze();
    do_reset();
    step();
    step();                       // counter = 2
    enable = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      set_m = (k == 3);
      m = 8'd5;
      step();
      vectors++;
      if (tick !== 1'b0) begin
        miscompares++;
        $display("FAIL freeze_tick k=%0d: got %b want 0", k, tick);
      end
    end
    set_m = 1'b0;
    vectors++;
    if (m_pending !== 1'b1 || m_active !== 8'd3) begin
      miscompares++;
      $display("FAIL freeze_capture: got p=%b m_active=%0d want 1 3", m_pending, m_active);
    end
    enable = 1'b1;
    step();
    vectors++;
    if (tick !== 1'b0) begin
      miscompares++;
      $display("FAIL freeze_resume1: got tick=%b want 0", tick);
    end
    step();
    vectors++;
    if (tick !== 1'b1 || m_active !== 8'd5 || m_pending !== 1'b0) begin
      miscompares++;
      $display("FAIL freeze_resume2: got tick=%b m_active=%0d p=%b want 1 5 0", tick, m_active, m_pending);
    end
    for (int k = 1; k <= 6; k++) begin
      step();
      vectors++;
      if (tick !== (k == 6)) begin
        miscompares++;
        $display("FAIL freeze_new_period k=%0d: got tick=%b want %b", k, tick, (k == 6));
      end
    end
  endtask

  task automatic test_sync_clr();
    logic [2:0] exp;
    do_reset();
    repeat (14) step();           // os_cnt = 3, counter = 2
    sync_clr = 1'b1;
    step();
    sync_clr = 1'b0;
    vectors++;
    if ({tick, mid_tick, bit_tick} !== 3'b000) begin
      miscompares++;
      $display("FAIL sync_clr_outputs: got %b want 000", {tick, mid_tick, bit_tick});
    end
    for (int k = 1; k <= 16; k++) begin
      step();
      exp = {(k % 4 == 0), (k == 8), (k == 16)};
      vectors++;
      if ({tick, mid_tick, bit_tick} !== exp) begin
        miscompares++;
        $display("FAIL sync_clr_seq k=%0d: got tick/mid/bit=%b want %b", k, {tick, mid_tick, bit_tick}, exp);
      end
    end
    set_m = 1'b1; m = 8'd1;
    step();
    set_m = 1'b0;
    sync_clr = 1'b1;
    step();
    sync_clr = 1'b0;
    vectors++;
    if (m_active !== 8'd1 || m_pending !== 1'b0) begin
      miscompares++;
      $display("FAIL sync_clr_apply: got m_active=%0d p=%b want 1 0", m_active, m_pending);
    end
    for (int k = 1; k <= 4; k++) begin
      step();
      vectors++;
      if (tick !== (k % 2 == 0)) begin
        miscompares++;
        $display("FAIL sync_clr_m1 k=%0d: got tick=%b want %b", k, tick, (k % 2 == 0));
      end
    end
  endtask

  task automatic test_m_zero();
    logic [2:0] exp;
    do_reset();
    set_m = 1'b1; m = 8'd0;
    step();
    set_m = 1'b0;
    repeat (3) step();            // cycle 4: wrap applies m = 0
    vectors++;
    if (tick !== 1'b1 || m_active !== 8'd0) begin
      miscompares++;
      $display("FAIL m_zero_apply: got tick=%b m_active=%0d want 1 0", tick, m_active);
    end
    for (int k = 1; k <= 8; k++) begin
      step();
      exp = {1'b1, (k % 4 == 1), (k % 4 == 3)};
      vectors++;
      if ({tick, mid_tick, bit_tick} !== exp) begin
        miscompares++;
        $display("FAIL m_zero_seq k=%0d: got tick/mid/bit=%b want %b", k, {tick, mid_tick, bit_tick}, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_m = 1'b1; m = 8'd9;
    step();
    m = 8'd2;
    step();
    set_m = 1'b0;
    step();
    step();                       // cycle 4: last value wins
    vectors++;
    if (tick !== 1'b1 || m_active !== 8'd2) begin
      miscompares++;
      $display("FAIL b2b_last_wins: got tick=%b m_active=%0d want 1 2", tick, m_active);
    end
    step();
    step();
    set_m = 1'b1; m = 8'd5;
    step();                       // cycle 7: wrap coincides with set_m
    set_m = 1'b0;
    vectors++;
    if (tick !== 1'b1 || m_active !== 8'd2 || m_pending !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_same_cycle: got tick=%b m_active=%0d p=%b want 1 2 1", tick, m_active, m_pending);
    end
    step();
    step();
    step();                       // cycle 10
    vectors++;
    if (tick !== 1'b1 || m_active !== 8'd5 || m_pending !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_following_wrap: got tick=%b m_active=%0d p=%b want 1 5 0", tick, m_active, m_pending);
    end
    for (int k = 1; k <= 6; k++) begin
      step();
      vectors++;
      if (tick !== (k == 6)) begin
        miscompares++;
        $display("FAIL b2b_period k=%0d: got tick=%b want %b", k, tick, (k == 6));
      end
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; sync_clr = 1'b0; set_m = 1'b0; m = 8'd0;
    test_reset();
    test_set_m();
    test_freeze();
    test_sync_clr();
    test_m_zero();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/baud_tick_gen.md
Name: baud_tick_gen

Overview:
- Parametrised baud-rate tick generator for the UART RX/TX datapath.
- Divides clk by a runtime-programmable modulus to produce a one-cycle oversample tick.
- A second-stage counter derives a bit tick and a mid-bit tick from the oversample tick.
- Adds glitch-free modulus update, phase restart (for start-bit alignment) and an enable/freeze control.

Parameters:
- CNT_W, 16: width of the divide counter and the modulus.
- INITIAL_M, 166: modulus loaded at reset. Tick period = M+1 clk cycles.
- OVERSAMPLE, 16: oversample ticks per bit. Must be an even number, at least 2.
- OS_W, 4: width of the oversample counter. Must satisfy 2^OS_W >= OVERSAMPLE.

Ports:
- clk  in  1  system clock. All logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  count enable. Low freezes all counters.
- sync_clr  in  1  restart divider and oversample phase from zero.
- set_m  in  1  strobe: capture m into the pending-modulus register.
- m  in  CNT_W  new modulus value.
- tick  out  1  oversample tick, one-cycle pulse.
- bit_tick  out  1  pulse on the last oversample tick of each bit.
- mid_tick  out  1  pulse on the oversample tick at the middle of each bit.
- m_active  out  CNT_W  modulus currently in use.
- m_pending  out  1  high while a captured modulus is waiting to be applied.

Behaviour:
- Reset (synchronous, highest priority):
  - counter = 0, os_cnt = 0.
  - m_active = INITIAL_M, pending register = INITIAL_M, m_pending = 0.
  - tick, bit_tick, mid_tick = 0.
- Priority order: reset > sync_clr > counting. set_m is evaluated in parallel with counting and never stalls the counter.
- Divide counter (enable = 1, no sync_clr):
  - If counter == m_active: counter <= 0, tick <= 1.
  - Otherwise: counter <= counter + 1, tick <= 0.
  - Period is m_active+1 cycles.
  - Latency: with enable held high from reset release, tick is first high in the cycle after the (M+1)th rising edge, then every M+1 cycles.
  - m = 0 gives tick high continuously.
- Oversample counter: advances on each cycle where the divide counter wraps.
  - os_cnt == OVERSAMPLE-1: os_cnt <= 0, bit_tick <= 1.
  - os_cnt == OVERSAMPLE/2-1: mid_tick <= 1.
  - bit_tick and mid_tick are each a one-cycle pulse, only ever coincident with tick.
- Modulus update:
  - set_m captures m into the pending register and sets m_pending.
  - The pending value is copied to m_active on the next divide-counter wrap; m_pending clears in that same cycle.
  - Consequence: the current period always completes with the old modulus, so no runt or stretched tick.
  - Repeated set_m before the wrap: the last value wins.
  - set_m in the same cycle as a wrap: the new m is captured and applied at the following wrap, not this one.
- enable = 0:
  - counter, os_cnt, the pending register and m_active hold.
  - tick, bit_tick, mid_tick are forced to 0.
  - set_m is still captured.
- sync_clr = 1 (regardless of enable):
  - counter <= 0, os_cnt <= 0, all tick outputs <= 0.
  - If m_pending is set, the pending value is applied immediately.
  - Next tick follows m_active+1 cycles after sync_clr deasserts.
- Widths: counter compare is over the full CNT_W bits; no truncation. The os_cnt compare uses OS_W bits.

Optional Feature:
- Macro: BAUD_TICK_FRAC_EN.
- With the macro defined:
  - Adds input m_frac [3:0] and a 4-bit fractional accumulator (reset to 0, cleared by sync_clr).
  - On each wrap the accumulator adds m_frac. If the add carries out, the next period is m_active+2 cycles instead of m_active+1.
  - Average period = m_active+1+m_frac/16.
  - m_frac is sampled by set_m together with m and follows the same pending/apply rule.
- Without the macro: no m_frac port and no accumulator; the period is always exactly m_active+1.

Test Plan:
- Reset, INITIAL_M=3, OVERSAMPLE=4, enable=1 -> tick high in cycles 4, 8, 12, 16; bit_tick coincident with the 4th tick (cycle 16); mid_tick with the 2nd tick (cycle 8).
- Counting with m_active=3; pulse set_m with m=7 when counter=1 -> m_pending=1 until the wrap; the current period stays 4 cycles; subsequent periods are 8 cycles; m_active reads 7 after the wrap.
- enable low for 10 cycles mid-period at counter=2 -> no tick during the freeze; after re-enable the next tick arrives exactly 2 cycles later (counter 2->3 then wrap).
- sync_clr pulse at counter=2, os_cnt=3 with m_active=3 -> counter and os_cnt are 0; next tick 4 cycles after release; bit_tick only after 4 further ticks.
- m=0 via set_m then one wrap -> tick high every cycle; with OVERSAMPLE=4, bit_tick every 4th cycle.
- (BAUD_TICK_FRAC_EN) m=9, m_frac=8 -> periods alternate 10,11,10,11; average 10.5 over 32 ticks.
